pps_capture: RTL and testbench

- Front end of the timestamp correction loop.
- Synchronises the external GPS PPS input and rejects glitches.
- On each qualified PPS rising edge, captures the free-running timestamp and presents it as a one-cycle-valid sample to the DDS correction stage.
- Also flags PPS loss and counts accepted pulses.

---
 rtl/pps_capture.sv | 161 ++++++++++++++++
 tb/tb_pps_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_capture.sv
// Synchronises and deglitches the GPS PPS input and captures the timestamp at the qualified rising edge (optional PPS_GLITCH_CNT_EN adds glitch_count).
// pps_valid is asserted FILTER_CYCLES cycles after the synchronised rise, and time_pps holds the timestamp from the rise cycle; there is no backpressure.
`timescale 1ns/1ps
module pps_capture #(
    parameter int          TIMESTAMP_WIDTH   = 64,
    parameter int          SYNC_STAGES       = 2,
    parameter int          FILTER_CYCLES     = 4,
    parameter logic [31:0] MIN_PERIOD_CYCLES = 32'd150000000,
    parameter logic [31:0] TIMEOUT_CYCLES    = 32'd170000000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       pps_in,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    input  logic                       enable,
    output logic [TIMESTAMP_WIDTH-1:0] time_pps,
    output logic                       pps_valid,
    output logic                       pps_lost,
`ifdef PPS_GLITCH_CNT_EN
    output logic [31:0]                pps_count,
    output logic [15:0]                glitch_count
`else
    output logic [31:0]                pps_count
`endif
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        QUALIFY  = 2'd2
    } state_t;

    localparam logic [7:0] FILT = 8'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0]     sync_q;
    state_t                     state_q;
    logic [7:0]                 qual_q;
    logic [TIMESTAMP_WIDTH-1:0] cand_q;
    logic [31:0]                period_q;
    logic                       first_q;
    logic [TIMESTAMP_WIDTH-1:0] time_pps_q;
    logic                       pps_valid_q;
    logic                       pps_lost_q;
    logic [31:0]                pps_count_q;

    logic                       s;
    logic [31:0]                period_inc;
    logic [31:0]                period_d;
    logic [7:0]                 qual_inc;
    logic                       accept_qual;
    logic                       accept_fast;
    logic                       accept;
    logic [TIMESTAMP_WIDTH-1:0] accept_ts;
    logic                       lost_d;
    logic                       holdoff_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pps_in};
        end
    end

    always_comb begin
        s            = sync_q[SYNC_STAGES-1];
        period_inc   = (period_q == 32'hFFFF_FFFF) ? period_q : period_q + 32'd1;
        qual_inc     = qual_q + 8'd1;
        accept_qual  = (state_q == QUALIFY) && enable && s && (qual_inc == FILT);
        // A one-cycle filter accepts straight from ARMED with the live timestamp.
        accept_fast  = (FILTER_CYCLES == 1) && (state_q == ARMED) && enable && s;
        accept       = accept_qual || accept_fast;
        accept_ts    = accept_fast ? timestamp : cand_q;
        period_d     = accept ? 32'd0 : period_inc;
        lost_d       = accept ? 1'b0
                              : (pps_lost_q || (first_q && (period_inc >= TIMEOUT_CYCLES)));
        holdoff_done = !first_q || (period_q >= MIN_PERIOD_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= WAIT_LOW;
            qual_q      <= 8'd0;
            cand_q      <= '0;
            period_q    <= 32'd0;
            first_q     <= 1'b0;
            time_pps_q  <= '0;
            pps_valid_q <= 1'b0;
            pps_lost_q  <= 1'b1;
            pps_count_q <= 32'd0;
        end else begin
            pps_valid_q <= accept;
            period_q    <= period_d;
            pps_lost_q  <= lost_d;
            if (accept) begin
                time_pps_q  <= accept_ts;
                pps_count_q <= pps_count_q + 32'd1;
                first_q     <= 1'b1;
            end
            case (state_q)
                WAIT_LOW: begin
                    // A low must be seen before re-arming, so a stuck-high input never retriggers.
                    if (!s && holdoff_done) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (s && enable) begin
                        cand_q  <= timestamp;
                        qual_q  <= 8'd1;
                        state_q <= accept_fast ? WAIT_LOW : QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (!enable) begin
                        state_q <= WAIT_LOW;
                    end else if (!s) begin
                        state_q <= ARMED;
                    end else if (accept_qual) begin
                        state_q <= WAIT_LOW;
                    end else begin
                        qual_q <= qual_inc;
                    end
                end
                default: state_q <= WAIT_LOW;
            endcase
        end
    end

`ifdef PPS_GLITCH_CNT_EN
    logic        s_prev_q;
    logic [15:0] glitch_q;
    logic        glitch_evt;

    // Counts filter aborts and rises that land inside the holdoff window.
    always_comb begin
        glitch_evt = ((state_q == QUALIFY) && enable && !s) ||
                     ((state_q == WAIT_LOW) && s && !s_prev_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_prev_q <= 1'b0;
            glitch_q <= 16'd0;
        end else begin
            s_prev_q <= s;
            if (glitch_evt && (glitch_q != 16'hFFFF)) begin
                glitch_q <= glitch_q + 16'd1;
            end
        end
    end

    assign glitch_count = glitch_q;
`endif

    assign time_pps  = time_pps_q;
    assign pps_valid = pps_valid_q;
    assign pps_lost  = pps_lost_q;
    assign pps_count = pps_count_q;

endmodule

// File: tb/tb_pps_capture.sv
// Directed bench for pps_capture: expected strobes go into a scoreboard, which a negedge monitor checks.
`timescale 1ns/1ps
module tb_pps_capture;

    typedef struct {
        logic [63:0] ts;
        logic [63:0] vcyc;
        logic [63:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pps_in;
    logic        enable;
    logic [63:0] cyc = 64'd0;
    logic [63:0] timestamp;
    logic [63:0] time_pps;
    logic        pps_valid;
    logic        pps_lost;
    logic [31:0] pps_count;
`ifdef PPS_GLITCH_CNT_EN
    logic [15:0] glitch_count;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    assign timestamp = cyc;

    pps_capture #(
        .TIMESTAMP_WIDTH  (64),
        .SYNC_STAGES      (2),
        .FILTER_CYCLES    (4),
        .MIN_PERIOD_CYCLES(32'd100),
        .TIMEOUT_CYCLES   (32'd300)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pps_in      (pps_in),
        .timestamp   (timestamp),
        .enable      (enable),
        .time_pps    (time_pps),
        .pps_valid   (pps_valid),
        .pps_lost    (pps_lost),
`ifdef PPS_GLITCH_CNT_EN
        .pps_count   (pps_count),
        .glitch_count(glitch_count)
`else
        .pps_count   (pps_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < 64'(n)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int ts, input int vcyc, input int cnt);
        exp_t e;
        e.ts   = 64'(ts);
        e.vcyc = 64'(vcyc);
        e.cnt  = 64'(cnt);
        sb.push_back(e);
    endtask

    // Monitor: every cycle the strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        exp_v = (sb.size() > 0) && (sb[0].vcyc == cyc);
        check("pps_valid", 64'(pps_valid), 64'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            check("time_pps", time_pps, e.ts);
            check("pps_count", 64'(pps_count), e.cnt);
            check("pps_lost_on_valid", 64'(pps_lost), 64'd0);
        end else if ((sb.size() > 0) && (sb[0].vcyc < cyc)) begin
            e = sb.pop_front();
            check("missed_valid_cycle", cyc, e.vcyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, expected end near 1820", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        pps_in = 1'b0;
        enable = 1'b1;

        at_cycle(3);
        @(negedge clk);
        check("rst_time_pps", time_pps, 64'd0);
        check("rst_pps_lost", 64'(pps_lost), 64'd1);
        check("rst_pps_count", 64'(pps_count), 64'd0);
`ifdef PPS_GLITCH_CNT_EN
        check("rst_glitch", 64'(glitch_count), 64'd0);
`endif
        at_cycle(4);
        resetn = 1'b1;

        // Clean pulse: s rises at 50, strobe at 54.
        at_cycle(48);
        expect_pulse(50, 54, 1);
        pps_in = 1'b1;
        at_cycle(53);
        @(negedge clk);
        check("lost_before_first", 64'(pps_lost), 64'd1);
        check("count_before_first", 64'(pps_count), 64'd0);
        at_cycle(58);
        pps_in = 1'b0;
        at_cycle(60);
        @(negedge clk);
        check("time_pps_hold", time_pps, 64'd50);

        // Rise at 114 is inside the holdoff window.
        at_cycle(112);
        pps_in = 1'b1;
        at_cycle(122);
        pps_in = 1'b0;
        at_cycle(130);
        @(negedge clk);
        check("count_after_holdoff", 64'(pps_count), 64'd1);
`ifdef PPS_GLITCH_CNT_EN
        check("glitch_holdoff", 64'(glitch_count), 64'd1);
`endif

        // Three-cycle glitch.
        at_cycle(160);
        pps_in = 1'b1;
        at_cycle(163);
        pps_in = 1'b0;
        at_cycle(170);
        @(negedge clk);
        check("count_after_glitch", 64'(pps_count), 64'd1);
`ifdef PPS_GLITCH_CNT_EN
        check("glitch_filter", 64'(glitch_count), 64'd2);
`endif

        // Pulse 120 cycles after the first accept.
        at_cycle(172);
        expect_pulse(174, 178, 2);
        pps_in = 1'b1;
        at_cycle(182);
        pps_in = 1'b0;

        // Timeout 300 cycles after the accept at 178.
        at_cycle(477);
        @(negedge clk);
        check("lost_477", 64'(pps_lost), 64'd0);
        check("time_pps_hold2", time_pps, 64'd174);
        at_cycle(478);
        @(negedge clk);
        check("lost_478", 64'(pps_lost), 64'd1);

        at_cycle(500);
        expect_pulse(502, 506, 3);
        pps_in = 1'b1;
        at_cycle(505);
        @(negedge clk);
        check("lost_505", 64'(pps_lost), 64'd1);
        at_cycle(510);
        pps_in = 1'b0;

        // enable drops during QUALIFY while the input stays high for 1000 cycles.
        at_cycle(620);
        pps_in = 1'b1;
        at_cycle(623);
        enable = 1'b0;
        at_cycle(805);
        @(negedge clk);
        check("lost_805", 64'(pps_lost), 64'd0);
        at_cycle(806);
        @(negedge clk);
        check("lost_806", 64'(pps_lost), 64'd1);
        at_cycle(1000);
        enable = 1'b1;
        at_cycle(1620);
        pps_in = 1'b0;
        at_cycle(1625);
        @(negedge clk);
        check("count_after_enable", 64'(pps_count), 64'd3);
        at_cycle(1630);
        expect_pulse(1632, 1636, 4);
        pps_in = 1'b1;
        at_cycle(1635);
        @(negedge clk);
        check("lost_1635", 64'(pps_lost), 64'd1);
        at_cycle(1640);
        pps_in = 1'b0;
        at_cycle(1650);
        @(negedge clk);
`ifdef PPS_GLITCH_CNT_EN
        check("glitch_after_enable", 64'(glitch_count), 64'd2);
`endif
        check("count_1650", 64'(pps_count), 64'd4);

        // Reset while a candidate is qualifying.
        at_cycle(1750);
        pps_in = 1'b1;
        at_cycle(1754);
        pps_in = 1'b0;
        resetn = 1'b0;
        at_cycle(1755);
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_time_pps", time_pps, 64'd0);
        check("mid_rst_lost", 64'(pps_lost), 64'd1);
        check("mid_rst_count", 64'(pps_count), 64'd0);
`ifdef PPS_GLITCH_CNT_EN
        check("mid_rst_glitch", 64'(glitch_count), 64'd0);
`endif

        // First pulse after reset needs no holdoff.
        at_cycle(1800);
        expect_pulse(1802, 1806, 1);
        pps_in = 1'b1;
        at_cycle(1805);
        @(negedge clk);
        check("lost_1805", 64'(pps_lost), 64'd1);
        at_cycle(1810);
        pps_in = 1'b0;

        at_cycle(1820);
        @(negedge clk);
        check("scoreboard_left", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
